// File: rtl/logic_gate_sweeper.sv
// Sequential gate-function sweeper: on start, walks every N_IN-bit input combination,
// evaluates the latched gate op on each one and assembles the full truth table.
module logic_gate_sweeper #(
   parameter int N_IN = 2,
   parameter int TT_W = 2**N_IN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   output logic            busy,
   output logic            out_valid,
   output logic [N_IN-1:0] vec_out,
   output logic            y_out,
   output logic            done,
   output logic [TT_W-1:0] truth_table,
   output logic            err
);

   localparam int CNT_W = N_IN + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TT_W - 1);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [2:0]        op_q, op_nx;
   logic [N_IN-1:0]   vec_nx;
   logic              y_nx, ov_nx, done_nx, err_nx, f_val;
   logic [TT_W-1:0]   tt_nx;
   logic [N_IN-1:0]   sel;

   assign sel  = cnt[N_IN-1:0];
   assign busy = (state == SWEEP);

   // Illegal op codes yield an all-zero table; err flags them separately.
   always_comb begin
      f_val = 1'b0;
      case (op_q)
         3'd0:    f_val = &sel;
         3'd1:    f_val = |sel;
         3'd2:    f_val = ~&sel;
         3'd3:    f_val = ~|sel;
         3'd4:    f_val = ^sel;
         3'd5:    f_val = ~^sel;
         default: f_val = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      op_nx    = op_q;
      vec_nx   = vec_out;
      y_nx     = y_out;
      ov_nx    = 1'b0;
      done_nx  = 1'b0;
      tt_nx    = truth_table;
      err_nx   = err;
      case (state)
         IDLE: begin
            if (start) begin
               op_nx    = op;
               cnt_nx   = '0;
               tt_nx    = '0;
               err_nx   = (op > 3'd5);
               state_nx = SWEEP;
            end
         end
         SWEEP: begin
            vec_nx     = sel;
            y_nx       = f_val;
            tt_nx[sel] = f_val;
            ov_nx      = 1'b1;
            if (cnt == LAST) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         op_q        <= '0;
         vec_out     <= '0;
         y_out       <= 1'b0;
         out_valid   <= 1'b0;
         done        <= 1'b0;
         truth_table <= '0;
         err         <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         op_q        <= op_nx;
         vec_out     <= vec_nx;
         y_out       <= y_nx;
         out_valid   <= ov_nx;
         done        <= done_nx;
         truth_table <= tt_nx;
         err         <= err_nx;
      end
   end

endmodule

// File: tb/tb_logic_gate_sweeper.sv
// Scoreboard bench for logic_gate_sweeper at N_IN = 2, 3 and 4 with directed,
// hand-computed truth tables.
module tb_logic_gate_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a   [3];
   logic        start_a [3];
   logic [2:0]  op_a    [3];
   logic        busy_a  [3];
   logic        ov_a    [3];
   logic        y_a     [3];
   logic        done_a  [3];
   logic        err_a   [3];
   logic [3:0]  vec_w   [3];
   logic [15:0] tt_w    [3];

   logic [1:0]  vec2;
   logic [2:0]  vec3;
   logic [3:0]  vec4;
   logic [3:0]  tt2;
   logic [7:0]  tt3;
   logic [15:0] tt4;

   assign vec_w[0] = {2'b00, vec2};
   assign vec_w[1] = {1'b0, vec3};
   assign vec_w[2] = vec4;
   assign tt_w[0]  = {12'h000, tt2};
   assign tt_w[1]  = {8'h00, tt3};
   assign tt_w[2]  = tt4;

   logic_gate_sweeper #(.N_IN(2)) u2 (
      .clk(clk), .rst_n(rst_a[0]), .start(start_a[0]), .op(op_a[0]),
      .busy(busy_a[0]), .out_valid(ov_a[0]), .vec_out(vec2), .y_out(y_a[0]),
      .done(done_a[0]), .truth_table(tt2), .err(err_a[0]));

   logic_gate_sweeper #(.N_IN(3)) u3 (
      .clk(clk), .rst_n(rst_a[1]), .start(start_a[1]), .op(op_a[1]),
      .busy(busy_a[1]), .out_valid(ov_a[1]), .vec_out(vec3), .y_out(y_a[1]),
      .done(done_a[1]), .truth_table(tt3), .err(err_a[1]));

   logic_gate_sweeper #(.N_IN(4)) u4 (
      .clk(clk), .rst_n(rst_a[2]), .start(start_a[2]), .op(op_a[2]),
      .busy(busy_a[2]), .out_valid(ov_a[2]), .vec_out(vec4), .y_out(y_a[2]),
      .done(done_a[2]), .truth_table(tt4), .err(err_a[2]));

   typedef struct {
      logic [3:0]  vec;
      logic        y;
      logic        done;
      logic [15:0] tt;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon(input int d);
      exp_t e;
      if (ov_a[d]) begin
         if (sb.size() == 0) begin
            chk($sformatf("unexpected_valid_dut%0d", d), 16'd1, 16'd0);
         end else begin
            e = sb.pop_front();
            chk("vec_out", vec_w[d], {12'h000, e.vec});
            chk("y_out", {15'h0, y_a[d]}, {15'h0, e.y});
            chk("done", {15'h0, done_a[d]}, {15'h0, e.done});
            chk("busy_in_sweep", {15'h0, busy_a[d]}, {15'h0, ~e.done});
            chk("err_in_sweep", {15'h0, err_a[d]}, {15'h0, e.err});
            if (e.done) chk("truth_table", tt_w[d], e.tt);
         end
      end else if (done_a[d]) begin
         chk($sformatf("done_without_valid_dut%0d", d), 16'd1, 16'd0);
      end
   endtask

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 3; d++) mon(d);
   end

   // Called at a negedge; returns at the negedge inside the done cycle.
   task automatic run(input int d, input logic [2:0] opv, input logic [15:0] tt,
                      input int n, input logic e, input bit disturb);
      exp_t x;
      int budget;
      for (int k = 0; k < n; k++) begin
         x.vec  = 4'(k);
         x.y    = tt[k];
         x.done = (k == n - 1);
         x.tt   = tt;
         x.err  = e;
         sb.push_back(x);
      end
      start_a[d] = 1'b1;
      op_a[d]    = opv;
      @(negedge clk);
      start_a[d] = 1'b0;
      chk("busy_after_start", {15'h0, busy_a[d]}, 16'd1);
      chk("gap_valid_low", {15'h0, ov_a[d]}, 16'd0);
      chk("err_at_start", {15'h0, err_a[d]}, {15'h0, e});
      @(negedge clk);
      chk("first_valid", {15'h0, ov_a[d]}, 16'd1);
      budget = 64;
      while (sb.size() != 0 && budget > 0) begin
         if (disturb && budget > 56) begin
            start_a[d] = 1'b1;
            op_a[d]    = ~op_a[d];
         end else begin
            start_a[d] = 1'b0;
         end
         @(negedge clk);
         budget--;
      end
      start_a[d] = 1'b0;
      if (sb.size() != 0) begin
         chk("sweep_timeout", 16'(sb.size()), 16'd0);
         sb.delete();
      end
   endtask

   task automatic idle_check(input int d);
      @(negedge clk);
      chk("idle_valid", {15'h0, ov_a[d]}, 16'd0);
      chk("idle_busy", {15'h0, busy_a[d]}, 16'd0);
      chk("idle_done", {15'h0, done_a[d]}, 16'd0);
   endtask

   task automatic zero_check(input int d, input string tag);
      chk({tag, "_busy"}, {15'h0, busy_a[d]}, 16'd0);
      chk({tag, "_valid"}, {15'h0, ov_a[d]}, 16'd0);
      chk({tag, "_vec"}, vec_w[d], 16'd0);
      chk({tag, "_y"}, {15'h0, y_a[d]}, 16'd0);
      chk({tag, "_done"}, {15'h0, done_a[d]}, 16'd0);
      chk({tag, "_tt"}, tt_w[d], 16'd0);
      chk({tag, "_err"}, {15'h0, err_a[d]}, 16'd0);
   endtask

   initial begin
      int budget;
      for (int d = 0; d < 3; d++) begin
         rst_a[d]   = 1'b0;
         start_a[d] = 1'b0;
         op_a[d]    = 3'd0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) zero_check(d, "reset");
      for (int d = 0; d < 3; d++) rst_a[d] = 1'b1;
      repeat (2) @(negedge clk);

      // AND, N_IN=2
      run(0, 3'd0, 16'h0008, 4, 1'b0, 1'b0);
      idle_check(0);

      // OR then NAND back-to-back
      run(0, 3'd1, 16'h000E, 4, 1'b0, 1'b0);
      run(0, 3'd2, 16'h0007, 4, 1'b0, 1'b0);
      idle_check(0);

      // XOR / XNOR, N_IN=3
      run(1, 3'd4, 16'h0096, 8, 1'b0, 1'b0);
      idle_check(1);
      run(1, 3'd5, 16'h0069, 8, 1'b0, 1'b0);
      idle_check(1);

      // illegal op, then legal NOR clears err
      run(0, 3'd6, 16'h0000, 4, 1'b1, 1'b0);
      idle_check(0);
      chk("err_sticky_idle", {15'h0, err_a[0]}, 16'd1);
      run(0, 3'd3, 16'h0001, 4, 1'b0, 1'b0);
      idle_check(0);

      // N_IN=4 with start/op disturbance mid-sweep
      run(2, 3'd0, 16'h8000, 16, 1'b0, 1'b1);
      idle_check(2);
      idle_check(2);

      // asynchronous reset after the second valid cycle
      for (int k = 0; k < 4; k++) begin
         exp_t x;
         x.vec = 4'(k); x.y = (k != 0); x.done = (k == 3); x.tt = 16'h000E; x.err = 1'b0;
         sb.push_back(x);
      end
      start_a[0] = 1'b1;
      op_a[0]    = 3'd1;
      @(negedge clk);
      start_a[0] = 1'b0;
      budget = 20;
      while (sb.size() > 2 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("reset_test_progress", 16'(sb.size()), 16'd2);
      #2 rst_a[0] = 1'b0;
      #1 zero_check(0, "async_reset");
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      zero_check(0, "held_reset");
      rst_a[0] = 1'b1;
      @(negedge clk);
      run(0, 3'd1, 16'h000E, 4, 1'b0, 1'b0);
      idle_check(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
